pc_redirect_ctrl: RTL and testbench

//  Sequences the fetch PC register of the 5-stage pipeline and owns the saved-PC (EPC) register.

---
 rtl/pc_redirect_ctrl.sv | 114 +++++++++++
 tb/tb_pc_redirect_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: fetch PC sequencer and EPC owner.
// Arbitrates exception entry/return, branch, jump, stall and sequential fetch,
// drives the IF/ID and ID/EX flush strobes, and holds a fixed-length drain
// window after exception entry.
module pc_redirect_ctrl #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080,
   parameter int          FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        br_taken_i,
   input  logic [31:0] br_target_i,
   input  logic        jump_i,
   input  logic [31:0] jump_target_i,
   input  logic        exc_req_i,
   input  logic [31:0] exc_pc_i,
   input  logic        exc_ret_i,
   output logic [31:0] pc_o,
   output logic [31:0] epc_o,
   output logic        flush_if_id_o,
   output logic        flush_id_ex_o,
   output logic        busy_o
);

   typedef enum logic {RUN, FLUSH} state_t;

   state_t      state_reg;
   logic [3:0]  cnt_reg;
   logic [31:0] pc_reg;
   logic [31:0] epc_reg;
   logic        busy_reg;

   logic [31:0] pc_next;
   logic [31:0] pc_seq;
   logic        enter_exc;

   assign pc_seq = pc_reg + 32'd4;   // wraps naturally modulo 2^32

   // Next-PC priority arbitration and flush strobes for the current cycle.
   always_comb begin
      pc_next       = pc_seq;
      enter_exc     = 1'b0;
      flush_if_id_o = 1'b0;
      flush_id_ex_o = 1'b0;
      if (rst) begin
         pc_next = RESET_VECTOR;
      end else if (state_reg == FLUSH) begin
         // Drain window: every request is ignored, fetch keeps streaming.
         flush_if_id_o = 1'b1;
         flush_id_ex_o = 1'b1;
      end else if (exc_req_i) begin
         enter_exc     = 1'b1;
         pc_next       = EXC_VECTOR;
         flush_if_id_o = 1'b1;
         flush_id_ex_o = 1'b1;
      end else if (exc_ret_i) begin
         pc_next       = epc_reg;
         flush_if_id_o = 1'b1;
         flush_id_ex_o = 1'b1;
      end else if (br_taken_i) begin
         pc_next       = {br_target_i[31:2], 2'b00};
         flush_if_id_o = 1'b1;
         flush_id_ex_o = 1'b1;
      end else if (jump_i) begin
         // Jump resolves in ID, so only the instruction behind it is wrong.
         pc_next       = {jump_target_i[31:2], 2'b00};
         flush_if_id_o = 1'b1;
      end else if (stall_i) begin
         pc_next = pc_reg;
      end
   end

   // State machine, PC/EPC registers and drain-window counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= RUN;
         cnt_reg   <= 4'd0;
         pc_reg    <= RESET_VECTOR;
         epc_reg   <= 32'd0;
         busy_reg  <= 1'b0;
      end else begin
         pc_reg <= pc_next;
         case (state_reg)
            RUN: begin
               if (enter_exc) begin
                  epc_reg   <= {exc_pc_i[31:2], 2'b00};
                  state_reg <= FLUSH;
                  cnt_reg   <= 4'(FLUSH_CYCLES - 1);
                  busy_reg  <= 1'b1;
               end
            end
            FLUSH: begin
               if (cnt_reg == 4'd0) begin
                  state_reg <= RUN;
                  busy_reg  <= 1'b0;
               end else begin
                  cnt_reg <= cnt_reg - 4'd1;
               end
            end
            default: begin
               state_reg <= RUN;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign pc_o   = pc_reg;
   assign epc_o  = epc_reg;
   assign busy_o = busy_reg;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl: inputs change on the falling edge,
// combinational flushes are checked just after that, registered outputs
// just after the following rising edge.
module tb_pc_redirect_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i, br_taken_i, jump_i, exc_req_i, exc_ret_i;
   logic [31:0] br_target_i, jump_target_i, exc_pc_i;
   logic [31:0] pc_o, epc_o;
   logic        flush_if_id_o, flush_id_ex_o, busy_o;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pc_redirect_ctrl #(
      .RESET_VECTOR(32'h0000_0000),
      .EXC_VECTOR  (32'h0000_0080),
      .FLUSH_CYCLES(2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .stall_i      (stall_i),
      .br_taken_i   (br_taken_i),
      .br_target_i  (br_target_i),
      .jump_i       (jump_i),
      .jump_target_i(jump_target_i),
      .exc_req_i    (exc_req_i),
      .exc_pc_i     (exc_pc_i),
      .exc_ret_i    (exc_ret_i),
      .pc_o         (pc_o),
      .epc_o        (epc_o),
      .flush_if_id_o(flush_if_id_o),
      .flush_id_ex_o(flush_id_ex_o),
      .busy_o       (busy_o)
   );

   task automatic clear_inputs();
      stall_i = 0; br_taken_i = 0; jump_i = 0; exc_req_i = 0; exc_ret_i = 0;
      br_target_i = 0; jump_target_i = 0; exc_pc_i = 0;
   endtask

   // Apply inputs at the falling edge, then settle combinational outputs.
   task automatic drive_phase();
      @(negedge clk);
      #1;
   endtask

   // Advance across the rising edge to observe registered outputs.
   task automatic edge_phase();
      @(posedge clk);
      #1;
   endtask

   // One cycle: check flush strobes before the edge, pc/epc/busy after it.
   task automatic cycle(input string name, input logic exp_fi, input logic exp_fe,
                        input logic [31:0] exp_pc, input logic [31:0] exp_epc,
                        input logic exp_busy);
      checks++;
      if (flush_if_id_o !== exp_fi || flush_id_ex_o !== exp_fe) begin
         failures++;
         $display("FAIL %s flush: got if_id=%b id_ex=%b, expected %b %b",
                  name, flush_if_id_o, flush_id_ex_o, exp_fi, exp_fe);
      end
      edge_phase();
      checks++;
      if (pc_o !== exp_pc || epc_o !== exp_epc || busy_o !== exp_busy) begin
         failures++;
         $display("FAIL %s regs: got pc=%h epc=%h busy=%b, expected pc=%h epc=%h busy=%b",
                  name, pc_o, epc_o, busy_o, exp_pc, exp_epc, exp_busy);
      end
      $display("txn %s pc=%h epc=%h fi=%b fe=%b busy=%b",
               name, pc_o, epc_o, flush_if_id_o, flush_id_ex_o, busy_o);
   endtask

   task automatic test_reset();
      drive_phase();
      clear_inputs();
      rst = 1; exc_req_i = 1; br_taken_i = 1; exc_pc_i = 32'h44;
      #1;
      cycle("reset", 0, 0, 32'h0, 32'h0, 0);
      drive_phase();
      clear_inputs(); rst = 0;
      #1;
      cycle("idle1", 0, 0, 32'h4, 32'h0, 0);
      drive_phase();
      cycle("idle2", 0, 0, 32'h8, 32'h0, 0);
      drive_phase();
      cycle("idle3", 0, 0, 32'hC, 32'h0, 0);
   endtask

   task automatic test_stall();
      drive_phase(); stall_i = 1; #1;
      cycle("stall1", 0, 0, 32'hC, 32'h0, 0);
      drive_phase();
      cycle("stall2", 0, 0, 32'hC, 32'h0, 0);
      drive_phase(); stall_i = 0; #1;
      cycle("stall_rel", 0, 0, 32'h10, 32'h0, 0);
   endtask

   task automatic test_redirect();
      drive_phase();
      br_taken_i = 1; br_target_i = 32'h40;
      jump_i = 1; jump_target_i = 32'h80; stall_i = 1;
      #1;
      cycle("br_over_jump", 1, 1, 32'h40, 32'h0, 0);
      drive_phase(); clear_inputs(); #1;
      cycle("after_br", 0, 0, 32'h44, 32'h0, 0);
      drive_phase(); jump_i = 1; jump_target_i = 32'h103; #1;
      cycle("jump_align", 1, 0, 32'h100, 32'h0, 0);
   endtask

   task automatic test_exception();
      drive_phase(); clear_inputs();
      exc_req_i = 1; exc_pc_i = 32'h1D; #1;
      cycle("exc_entry", 1, 1, 32'h80, 32'h1C, 1);
      drive_phase();
      exc_pc_i = 32'h200; br_taken_i = 1; br_target_i = 32'h300; exc_ret_i = 1; stall_i = 1;
      #1;
      cycle("flush1", 1, 1, 32'h84, 32'h1C, 1);
      drive_phase();
      cycle("flush2", 1, 1, 32'h88, 32'h1C, 0);
      drive_phase(); clear_inputs(); #1;
      cycle("post_flush", 0, 0, 32'h8C, 32'h1C, 0);
   endtask

   task automatic test_exc_return();
      drive_phase(); exc_ret_i = 1; #1;
      cycle("eret", 1, 1, 32'h1C, 32'h1C, 0);
      drive_phase(); clear_inputs(); #1;
      cycle("after_eret", 0, 0, 32'h20, 32'h1C, 0);
   endtask

   task automatic test_reset_in_flush_and_wrap();
      drive_phase(); exc_req_i = 1; exc_pc_i = 32'h44; #1;
      cycle("exc2_entry", 1, 1, 32'h80, 32'h44, 1);
      drive_phase(); clear_inputs(); rst = 1; #1;
      cycle("rst_mid_flush", 0, 0, 32'h0, 32'h0, 0);
      drive_phase(); rst = 0; jump_i = 1; jump_target_i = 32'hFFFF_FFFC; #1;
      cycle("jump_top", 1, 0, 32'hFFFF_FFFC, 32'h0, 0);
      drive_phase(); clear_inputs(); #1;
      cycle("wrap", 0, 0, 32'h0, 32'h0, 0);
   endtask

   initial begin
      rst = 1;
      clear_inputs();
      test_reset();
      test_stall();
      test_redirect();
      test_exception();
      test_exc_return();
      test_reset_in_flush_and_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
